// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate pipe: op encodings, FSM states and
// the mapping from a packet's op to the function that folds its beats.
package logic_gate_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NAND  = 3'd3;
    localparam logic [2:0] OP_NOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_NOTA  = 3'd6;
    localparam logic [2:0] OP_PASSA = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        COMB_AND  = 2'd0,
        COMB_OR   = 2'd1,
        COMB_XOR  = 2'd2,
        COMB_LAST = 2'd3
    } comb_e;

    // Inverting ops fold with their non-inverted base; unary ops keep the last beat.
    function automatic comb_e g_select(input logic [2:0] op);
        case (op)
            OP_AND, OP_NAND: return COMB_AND;
            OP_OR,  OP_NOR:  return COMB_OR;
            OP_XOR, OP_XNOR: return COMB_XOR;
            default:         return COMB_LAST;
        endcase
    endfunction

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Beat-in / result-out bus of the logic gate pipe.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// a producer holding valid=1 keeps its payload stable until that edge.
interface logic_gate_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    import logic_gate_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_en;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic [CNT_W-1:0] out_beats;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, op, acc_en, in_last, in_valid, out_ready,
        input  in_ready, y, out_beats, out_valid
    );

    modport slave (
        input  a, b, op, acc_en, in_last, in_valid, out_ready,
        output in_ready, y, out_beats, out_valid
    );

endinterface

// File: rtl/logic_gate_core.sv
// Combinational bitwise gate: r = f(a, b, op).
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] r
);

    always_comb begin
        r = '0;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XNOR:  r = ~(a ^ b);
            OP_NOTA:  r = ~a;
            OP_PASSA: r = a;
            default:  r = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered bitwise gate with optional per-packet accumulation of beats into
// one result, a saturating beat count and a single-entry output register.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    logic_gate_pipe_if.slave    bus,
    output state_e              fsm_state
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             valid_q, valid_d;

    logic             in_ready;
    logic             accept;
    logic [2:0]       core_op;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] folded;
    logic [CNT_W-1:0] count_inc;

    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Mid-packet beats are evaluated with the op captured at the first beat.
    assign core_op = (state_q == ACCUM) ? op_q : bus.op;

    logic_gate_core #(.WIDTH(WIDTH)) u_core (
        .a  (bus.a),
        .b  (bus.b),
        .op (core_op),
        .r  (r)
    );

    always_comb begin
        folded = r;
        case (g_select(op_q))
            COMB_AND: folded = acc_q & r;
            COMB_OR:  folded = acc_q | r;
            COMB_XOR: folded = acc_q ^ r;
            default:  folded = r;
        endcase
    end

    assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            op_q    <= '0;
            y_q     <= '0;
            beats_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            op_q    <= op_d;
            y_q     <= y_d;
            beats_q <= beats_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                IDLE:    if (bus.acc_en && !bus.in_last) state_d = ACCUM;
                ACCUM:   if (bus.in_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        logic load_out;
        load_out = 1'b0;
        acc_d    = acc_q;
        count_d  = count_q;
        op_d     = op_q;
        y_d      = y_q;
        beats_d  = beats_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!bus.acc_en || bus.in_last) begin
                        load_out = 1'b1;
                        y_d      = r;
                        beats_d  = CNT_W'(1);
                    end else begin
                        acc_d   = r;
                        count_d = CNT_W'(1);
                        op_d    = bus.op;
                    end
                end
                ACCUM: begin
                    if (bus.in_last) begin
                        load_out = 1'b1;
                        y_d      = folded;
                        beats_d  = count_inc;
                    end else begin
                        acc_d   = folded;
                        count_d = count_inc;
                    end
                end
                default: ;
            endcase
        end
        // A fresh result wins; otherwise the pending one drains on acceptance.
        valid_d = load_out || (valid_q && !bus.out_ready);
    end

    assign bus.in_ready  = in_ready;
    assign bus.y         = y_q;
    assign bus.out_beats = beats_q;
    assign bus.out_valid = valid_q;
    assign fsm_state     = state_q;

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, minimum 1.
REQ-002 Parameter CNT_W, default 8: width of the beat counter output, minimum 1.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port a  input  WIDTH  operand A.
REQ-006 Port b  input  WIDTH  operand B.
REQ-007 Port op  input  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT-a, 7 PASS-a.
REQ-008 Port acc_en  input  1  when 1, accumulate beats into one result per packet.
REQ-009 Port in_last  input  1  marks the last beat of a packet; ignored when acc_en=0.
REQ-010 Port in_valid  input  1  input beat present.
REQ-011 Port in_ready  output  1  block accepts a beat this cycle.
REQ-012 Port y  output  WIDTH  result.
REQ-013 Port out_beats  output  CNT_W  number of beats folded into y.
REQ-014 Port out_valid  output  1  y and out_beats valid.
REQ-015 Port out_ready  input  1  downstream accepts the result.

Function
REQ-016 A beat is accepted when in_valid and in_ready are both 1; y is accepted when out_valid and out_ready are both 1.
REQ-017 in_ready SHALL equal (!out_valid || out_ready) combinationally, giving full throughput with a single output register.
REQ-018 Per-beat result r = f(a, b, op), bitwise, with the op encodings of REQ-007.
REQ-019 Latency: a result-producing beat accepted in cycle N SHALL drive out_valid=1 with y and out_beats in cycle N+1.
REQ-020 y and out_beats SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 out_valid SHALL clear after output acceptance unless a new result is loaded in the same cycle.
REQ-022 acc_en=0: every accepted beat SHALL produce y=r and out_beats=1.
REQ-023 State machine, state IDLE: an accepted beat with acc_en=1 and in_last=0 SHALL load acc=r, set count=1, latch op, and move to ACCUM.
REQ-024 State machine, state IDLE: an accepted beat with acc_en=1 and in_last=1 SHALL output y=r with out_beats=1 and stay in IDLE.
REQ-025 State ACCUM: each accepted beat SHALL set acc = g(acc, r), using the latched op.
REQ-026 State ACCUM: the combining function g SHALL be AND for ops 0 and 3, OR for ops 1 and 4, XOR for ops 2 and 5, and last-beat-wins (acc=r) for ops 6 and 7.
REQ-027 State ACCUM: the op and acc_en inputs SHALL be ignored; the op latched at the first beat governs the whole packet.
REQ-028 State ACCUM: a beat with in_last=1 SHALL output y=g(acc, r) with out_beats=count+1 and return to IDLE.
REQ-029 Non-last beats in ACCUM SHALL not change y, out_beats or out_valid.
REQ-030 The beat count SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-031 A beat not accepted (in_ready=0) SHALL change no state.

Reset
REQ-032 While rst=1 at a clock edge: out_valid=0, y=0, out_beats=0, acc=0, count=0, latched op=0, state=IDLE.
REQ-033 Reset mid-packet or mid-stall SHALL discard the partial packet and the pending output without emitting a result.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-035 Package logic_gate_pkg SHALL hold the op encoding constants, the state enumeration (IDLE, ACCUM) and the g-selection function.
REQ-036 Sub-module logic_gate_core SHALL implement the combinational f(a, b, op) at WIDTH bits; all sequential logic stays in logic_gate_pipe.

Verification (WIDTH=8, CNT_W=8)
REQ-037 Single beat: op=1, a=0x0F, b=0xF0, acc_en=0 -> next cycle out_valid=1, y=0xFF, out_beats=1.
REQ-038 All ops: a=0xCC, b=0xAA, ops 0..7 -> y = 0x88, 0xEE, 0x66, 0x77, 0x11, 0x99, 0x33, 0xCC.
REQ-039 OR accumulate: beats (0x01,0x00), (0x02,0x00), (0x80,0x00,last) with op=1, acc_en=1 -> exactly one output, y=0x83, out_beats=3.
REQ-040 Backpressure: hold out_ready=0 with a result pending -> in_ready=0 and y stable for 5 cycles; on release, the next beat is accepted in the same cycle.
REQ-041 Reset mid-ACCUM: after 2 beats, pulse rst -> out_valid=0, no output emitted; the next single beat gives out_beats=1.
REQ-042 Saturation: 300-beat packet with op=2 -> out_beats=255, y = XOR of all r.
